// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle with clock and reset carried alongside.
// The master drives the request side, the slave answers with ack/err/stall.
interface wb_if;
    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        input  clk, rst, dat_i, ack, stall, err,
        output cyc, stb, we, sel, adr, dat_o
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack, stall, err
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined initiator driven by a valid/ready
// command port, with a bounded timeout that forces an error response.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    wb_if.master        wb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rv_q, rv_d;
    logic [31:0] rd_q, rd_d;
    logic        re_q, re_d;
    logic [15:0] cnt_q, cnt_d;

    logic        expired;
    logic        done;
    logic        done_err;
    logic [31:0] done_dat;
    logic        unused_adr;

    assign unused_adr = ^req_adr[1:0];
    assign expired    = (cnt_q == TLAST);

    assign req_ready = (state_q == IDLE) && !wb.rst;
    assign wb.cyc    = cyc_q;
    assign wb.stb    = stb_q;
    assign wb.we     = we_q;
    assign wb.sel    = 4'hF;
    assign wb.adr    = adr_q;
    assign wb.dat_o  = dat_q;
    assign rsp_valid = rv_q;
    assign rsp_dat   = rd_q;
    assign rsp_err   = re_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rv_d     = rv_q;
        rd_d     = rd_q;
        re_d     = re_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        done_err = 1'b0;
        done_dat = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = req_we;
                    adr_d   = {req_adr[31:2], 2'b00};
                    dat_d   = req_dat;
                    cnt_d   = 16'd0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                // ack/err cannot belong to this request yet
                if (expired) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (!wb.stall) begin
                    stb_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (wb.err) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (wb.ack) begin
                    done     = 1'b1;
                    done_dat = we_q ? 32'd0 : wb.dat_i;
                end else if (expired) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
        if (done) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            rv_d    = 1'b1;
            re_d    = done_err;
            rd_d    = done_dat;
            state_d = RSP;
        end
    end

    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            rv_q    <= 1'b0;
            rd_q    <= 32'd0;
            re_q    <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            re_q    <= re_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed vector table, hand-written
// reset sequence and randomized transactions against a timing/memory model.
module tb_wb_cmd_master;

    localparam int TO = 8;

    wb_if wb ();

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    wb_cmd_master #(.TIMEOUT(TO)) dut (
        .wb        (wb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err)
    );

    initial wb.clk = 1'b0;
    always #5 wb.clk = ~wb.clk;

    // slave: configurable stall count, response latency and response kind
    // mode 0 = ack, 1 = err, 2 = ack+err, 3 = silent
    int          cfg_stall;
    int          cfg_lat;
    int          cfg_mode;
    logic [31:0] smem [16];
    logic [31:0] srd;
    logic        spend;
    int          swait;
    int          sstall_n;

    assign wb.stall = wb.stb && (sstall_n < cfg_stall);
    assign wb.ack   = wb.cyc && spend && swait == 0 &&
                      (cfg_mode == 0 || cfg_mode == 2);
    assign wb.err   = wb.cyc && spend && swait == 0 &&
                      (cfg_mode == 1 || cfg_mode == 2);
    assign wb.dat_i = srd;

    always @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            spend    <= 1'b0;
            swait    <= 0;
            sstall_n <= 0;
            srd      <= 32'd0;
        end else begin
            if (!wb.stb) sstall_n <= 0;
            else if (wb.stall) sstall_n <= sstall_n + 1;
            if (wb.cyc && wb.stb && !wb.stall) begin
                spend <= 1'b1;
                swait <= cfg_lat - 1;
                srd   <= smem[wb.adr[5:2]];
                if (wb.we) smem[wb.adr[5:2]] <= wb.dat_o;
            end else if (!wb.cyc) begin
                spend <= 1'b0;
            end else if (spend && swait != 0) begin
                swait <= swait - 1;
            end else if (spend) begin
                spend <= 1'b0;
            end
        end
    end

    int n_pass;
    int n_total;
    logic [31:0] model_mem [16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Cycle numbering: 0 = request handshake, 1 = cyc rises.
    // Returns whether the slave accepts, the error flag and response cycle.
    task automatic predict(input int s, input int lat, input int mode,
                           output logic acc, output logic err,
                           output int rcyc);
        int a;
        if (s + 1 >= TO) begin
            acc  = 1'b0;
            err  = 1'b1;
            rcyc = TO + 1;
        end else begin
            acc = 1'b1;
            a   = 1 + s + lat;
            if (mode != 3 && a <= TO) begin
                err  = (mode != 0);
                rcyc = a + 1;
            end else begin
                err  = 1'b1;
                rcyc = TO + 1;
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input int s, input int lat, input int mode,
                           input int rdy, input logic use_tab,
                           input logic t_err, input logic [31:0] t_dat,
                           input int t_lat);
        logic        acc, perr, got, stable;
        int          pcyc, n, stbn, cycn;
        logic [31:0] pdat;
        logic        e_err;
        logic [31:0] e_dat;
        int          e_lat;
        predict(s, lat, mode, acc, perr, pcyc);
        pdat = (perr || we) ? 32'd0 : model_mem[adr[5:2]];
        if (we && acc) model_mem[adr[5:2]] = dat;
        e_err = use_tab ? t_err : perr;
        e_dat = use_tab ? t_dat : pdat;
        e_lat = use_tab ? t_lat : pcyc;
        cfg_stall = s;
        cfg_lat   = lat;
        cfg_mode  = mode;
        @(negedge wb.clk);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        @(negedge wb.clk);
        req_valid = 1'b0;
        req_adr   = $urandom;
        req_dat   = $urandom;
        n = 1; stbn = 0; cycn = 0; stable = 1'b1; got = 1'b0;
        while (n <= 40 && !got) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                stbn += int'(wb.stb);
                cycn += int'(wb.cyc);
                if (wb.stb && (wb.adr !== {adr[31:2], 2'b00} ||
                    wb.we !== we || wb.dat_o !== dat || wb.sel !== 4'hF))
                    stable = 1'b0;
                if (we && acc && n == s + 2)
                    chk({tag, " wr_visible"}, 64'(smem[adr[5:2]]), 64'(dat));
                @(negedge wb.clk);
                n++;
            end
        end
        chk({tag, " latency"}, 64'(n), 64'(e_lat));
        if (!got) return;
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'(e_err));
        chk({tag, " rsp_dat"}, 64'(rsp_dat), 64'(e_dat));
        chk({tag, " stb_cycles"}, 64'(stbn), 64'(acc ? s + 1 : TO));
        chk({tag, " cyc_cycles"}, 64'(cycn), 64'(e_lat - 1));
        chk({tag, " req_stable"}, 64'(stable), 64'd1);
        for (int i = 0; i < rdy; i++) begin
            chk({tag, " hold"},
                {29'd0, req_ready, rsp_valid, rsp_err, wb.cyc, rsp_dat},
                {29'd0, 1'b0, 1'b1, e_err, 1'b0, e_dat});
            @(negedge wb.clk);
        end
        rsp_ready = 1'b1;
        chk({tag, " rdy_at_hs"}, 64'(req_ready), 64'd0);
        @(negedge wb.clk);
        rsp_ready = 1'b0;
        chk({tag, " after_hs"}, {62'd0, req_ready, rsp_valid}, 64'b10);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          s;
        int          lat;
        int          mode;
        int          rdy;
        logic        e_err;
        logic [31:0] e_dat;
        int          e_lat;
    } vec_t;

    vec_t vt [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [31:0] adr, dat;
        int          s, lat, mode, m;
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 16; i++) begin
            smem[i] = 32'd0;
            model_mem[i] = 32'd0;
        end
        cfg_stall = 0; cfg_lat = 1; cfg_mode = 0;
        req_valid = 0; req_we = 0; req_adr = 0; req_dat = 0;
        rsp_ready = 0;

        vt[0]  = '{1'b1, 32'h0,  32'hA,        0, 1, 0, 0, 1'b0, 32'h0,        3};
        vt[1]  = '{1'b0, 32'h0,  32'h0,        0, 1, 0, 0, 1'b0, 32'hA,        3};
        vt[2]  = '{1'b1, 32'h16, 32'h12345678, 3, 1, 0, 0, 1'b0, 32'h0,        6};
        vt[3]  = '{1'b0, 32'h14, 32'h0,        0, 1, 3, 0, 1'b1, 32'h0,        9};
        vt[4]  = '{1'b0, 32'h14, 32'h0,        0, 7, 0, 0, 1'b0, 32'h12345678, 9};
        vt[5]  = '{1'b0, 32'h14, 32'h0,        0, 8, 0, 0, 1'b1, 32'h0,        9};
        vt[6]  = '{1'b0, 32'h14, 32'h0,        0, 1, 2, 0, 1'b1, 32'h0,        3};
        vt[7]  = '{1'b0, 32'h14, 32'h0,        0, 1, 1, 5, 1'b1, 32'h0,        3};
        vt[8]  = '{1'b1, 32'h8,  32'hDEADBEEF, 8, 1, 0, 0, 1'b1, 32'h0,        9};
        vt[9]  = '{1'b0, 32'h8,  32'h0,        0, 1, 0, 2, 1'b0, 32'h0,        3};
        vt[10] = '{1'b1, 32'h4,  32'h55AA,     1, 2, 0, 1, 1'b0, 32'h0,        5};

        wb.rst = 1'b1;
        repeat (2) @(negedge wb.clk);
        chk("reset_bus", {27'd0, wb.cyc, wb.stb, wb.we, 1'b0, req_ready, wb.adr},
            64'd0);
        chk("reset_dat_o", 64'(wb.dat_o), 64'd0);
        chk("reset_rsp", {31'd0, rsp_valid, rsp_err, rsp_dat}, 64'd0);
        wb.rst = 1'b0;
        @(negedge wb.clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 11; i++)
            run_txn($sformatf("vec%0d", i), vt[i].we, vt[i].adr, vt[i].dat,
                    vt[i].s, vt[i].lat, vt[i].mode, vt[i].rdy, 1'b1,
                    vt[i].e_err, vt[i].e_dat, vt[i].e_lat);

        // reset while the bus cycle waits for a slow ack
        cfg_stall = 0; cfg_lat = 5; cfg_mode = 0;
        @(negedge wb.clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0;
        @(negedge wb.clk);
        req_valid = 1'b0;
        @(negedge wb.clk);
        chk("midwait_cyc_before", {62'd0, wb.cyc, wb.stb}, 64'b10);
        wb.rst = 1'b1;
        #1;
        chk("midwait_reset",
            {60'd0, wb.cyc, wb.stb, rsp_valid, req_ready}, 64'd0);
        @(negedge wb.clk);
        wb.rst = 1'b0;
        @(negedge wb.clk);
        chk("midwait_release",
            {60'd0, req_ready, wb.cyc, wb.stb, rsp_valid}, 64'b1000);
        run_txn("post_reset", 1'b0, 32'h0, 32'h0, 0, 1, 0, 0, 1'b1,
                1'b0, 32'hA, 3);

        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom);
            adr  = $urandom;
            dat  = $urandom;
            s    = int'($urandom_range(0, 9));
            lat  = int'($urandom_range(1, 9));
            m    = int'($urandom_range(0, 5));
            mode = (m < 3) ? 0 : m - 2;
            run_txn($sformatf("rnd%0d", i), we, adr, dat, s, lat, mode,
                    int'($urandom_range(0, 3)), 1'b0, 1'b0, 32'd0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
